// File: rtl/ad_frame_packer.sv
// ad_frame_packer: frames AD cache blocks into USB packets in TX-buffer RAM.
// Packet layout: HDR_WORD, seq, {ovf_cnt,7'b0,en}, NSAMP samples, checksum.
//
// Ports:
//   mclk, reset_n         clock, async active-low reset
//   en                    acquisition enable (level)
//   ad_switch             cache half-switch, every toggle = one block ready
//   ad_rd / ad_data       cache read strobe, data valid one cycle later
//   tx_vd/tx_addr/tx_data TX-buffer write port, addr = {block, word}
//   tx_eop / tx_baddr     stretched packet-complete pulse and its block
//   ovf_cnt               saturating count of dropped switch events
//   busy                  packer not idle
//
// Optional: `define AD_PACKER_RAMP_EN replaces the payload with a
// {seq[7:0], k[7:0]} ramp; the cache is still read identically.

module ad_frame_packer #(
    parameter int                DATA_W   = 16,
    parameter int                BADDR_W  = 3,
    parameter int                WADDR_W  = 8,
    parameter logic [DATA_W-1:0] HDR_WORD = 16'hEB90,
    parameter int                EOP_HOLD = 4
) (
    input  logic                       mclk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic                       ad_switch,
    output logic                       ad_rd,
    input  logic [DATA_W-1:0]          ad_data,
    output logic                       tx_vd,
    output logic [BADDR_W+WADDR_W-1:0] tx_addr,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_eop,
    output logic [BADDR_W-1:0]         tx_baddr,
    output logic [7:0]                 ovf_cnt,
    output logic                       busy
);

    localparam int NSAMP = 2**WADDR_W - 4;
    localparam int HW    = $clog2(EOP_HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_SEQ, S_STAT, S_PAY, S_CSUM, S_EOP
    } state_t;

    state_t              state, state_nx;
    logic                sw_s1, sw_s2, sw_prev, sw_init;
    logic                en_d;
    logic [DATA_W-1:0]   seq, csum, sample;
    logic [BADDR_W-1:0]  bptr;
    logic [7:0]          ovf;
    logic [WADDR_W-1:0]  cnt, word;
    logic [HW-1:0]       hold;
    logic                sw_event, en_rise, accept, drop;
    logic [7:0]          ovf_base;

    // sw_init masks the sync chain until it has been preloaded, so a
    // high ad_switch at reset release is not mistaken for a toggle.
    assign sw_event = sw_init & (sw_s2 ^ sw_prev);
    assign en_rise  = en & ~en_d;
    assign accept   = (state == S_IDLE) & sw_event & en;
    assign drop     = (state != S_IDLE) & sw_event & en;
    assign ovf_base = en_rise ? 8'd0 : ovf;

`ifdef AD_PACKER_RAMP_EN
    assign sample = DATA_W'({seq[7:0], 8'(cnt)});
`else
    assign sample = ad_data;
`endif

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (accept) state_nx = S_HDR;
            S_HDR:  state_nx = S_SEQ;
            S_SEQ:  state_nx = S_STAT;
            S_STAT: state_nx = S_PAY;
            S_PAY:  if (cnt == WADDR_W'(NSAMP - 1)) state_nx = S_CSUM;
            S_CSUM: state_nx = S_EOP;
            S_EOP:  if (hold == HW'(EOP_HOLD - 1)) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        tx_vd   = 1'b0;
        tx_eop  = 1'b0;
        ad_rd   = 1'b0;
        word    = '0;
        tx_data = '0;
        unique case (state)
            S_HDR: begin
                tx_vd   = 1'b1;
                tx_data = HDR_WORD;
            end
            S_SEQ: begin
                tx_vd   = 1'b1;
                word    = WADDR_W'(1);
                tx_data = seq;
            end
            S_STAT: begin
                tx_vd   = 1'b1;
                ad_rd   = 1'b1;
                word    = WADDR_W'(2);
                tx_data = DATA_W'({ovf, 7'b0, en});
            end
            S_PAY: begin
                tx_vd   = 1'b1;
                // last read was issued one cycle before the last write
                ad_rd   = (cnt < WADDR_W'(NSAMP - 1));
                word    = WADDR_W'(3) + cnt;
                tx_data = sample;
            end
            S_CSUM: begin
                tx_vd   = 1'b1;
                word    = '1;
                tx_data = csum;
            end
            S_EOP:  tx_eop = 1'b1;
            default: ;
        endcase
    end

    assign tx_addr  = tx_vd ? {bptr, word} : '0;
    assign tx_baddr = bptr;
    assign ovf_cnt  = ovf;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            sw_s1   <= 1'b0;
            sw_s2   <= 1'b0;
            sw_prev <= 1'b0;
            sw_init <= 1'b0;
        end else if (!sw_init) begin
            sw_s1   <= ad_switch;
            sw_s2   <= ad_switch;
            sw_prev <= ad_switch;
            sw_init <= 1'b1;
        end else begin
            sw_s1   <= ad_switch;
            sw_s2   <= sw_s1;
            sw_prev <= sw_s2;
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            en_d <= 1'b0;
            seq  <= '0;
            ovf  <= '0;
            bptr <= '0;
            cnt  <= '0;
            hold <= '0;
            csum <= '0;
        end else begin
            en_d <= en;
            // en rise clears first; a CSUM in the same cycle then counts
            seq  <= (en_rise ? '0 : seq) + DATA_W'(state == S_CSUM);
            ovf  <= (drop && ovf_base != 8'hFF) ? ovf_base + 8'd1 : ovf_base;
            // block 0 belongs to handshake traffic: wrap back to 1
            if (accept)
                bptr <= (bptr == '1) ? BADDR_W'(1) : bptr + BADDR_W'(1);
            cnt  <= (state == S_PAY) ? cnt + WADDR_W'(1) : '0;
            hold <= (state == S_EOP) ? hold + HW'(1) : '0;
            if (state == S_HDR)
                csum <= '0;
            else if (state == S_PAY)
                csum <= csum + sample;
        end
    end

endmodule

// File: tb/tb_ad_frame_packer.sv
// tb_ad_frame_packer: directed bench for ad_frame_packer.
// Cache model returns index mod 252; writes are captured into a RAM image.

module tb_ad_frame_packer;

    logic        mclk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        ad_switch;
    logic        ad_rd;
    logic [15:0] ad_data;
    logic        tx_vd;
    logic [10:0] tx_addr;
    logic [15:0] tx_data;
    logic        tx_eop;
    logic [2:0]  tx_baddr;
    logic [7:0]  ovf_cnt;
    logic        busy;

    ad_frame_packer dut (
        .mclk      (mclk),
        .reset_n   (reset_n),
        .en        (en),
        .ad_switch (ad_switch),
        .ad_rd     (ad_rd),
        .ad_data   (ad_data),
        .tx_vd     (tx_vd),
        .tx_addr   (tx_addr),
        .tx_data   (tx_data),
        .tx_eop    (tx_eop),
        .tx_baddr  (tx_baddr),
        .ovf_cnt   (ovf_cnt),
        .busy      (busy)
    );

    always #5 mclk = ~mclk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge mclk) cyc <= cyc + 1;

    int rd_idx;
    always @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            rd_idx  <= 0;
            ad_data <= 16'h0;
        end else if (ad_rd) begin
            ad_data <= 16'(rd_idx % 252);
            rd_idx  <= rd_idx + 1;
        end
    end

    logic [15:0] mem [0:2047];
    int vd_cnt = 0, rd_cnt = 0, eop_cnt = 0, low_hits = 0;
    int first_vd = -1, last_vd = -1, eop_rise = -1;
    logic vd_prev = 1'b0, eop_prev = 1'b0;

    always @(negedge mclk) begin
        if (tx_vd) begin
            vd_cnt++;
            if (!vd_prev) first_vd = cyc;
            last_vd = cyc;
            mem[tx_addr] = tx_data;
            if (tx_addr < 11'h100) low_hits++;
        end
        if (ad_rd) rd_cnt++;
        if (tx_eop) begin
            eop_cnt++;
            if (!eop_prev) eop_rise = cyc;
        end
        vd_prev  = tx_vd;
        eop_prev = tx_eop;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] exp_sample(input logic [15:0] s,
                                               input int k);
`ifdef AD_PACKER_RAMP_EN
        return {s[7:0], 8'(k)};
`else
        return 16'(k);
`endif
    endfunction

    function automatic logic [63:0] outs();
        return {tx_vd, tx_eop, ad_rd, busy, tx_addr, tx_data,
                tx_baddr, ovf_cnt};
    endfunction

    task automatic run_packet(input int blk, input logic [15:0] s,
                              input logic [15:0] stat,
                              input int drop_at, input int en_off_at);
        int t0, vd0, rd0, e0, bad;
        logic [15:0] sum;
        @(posedge mclk); #1;
        vd0 = vd_cnt; rd0 = rd_cnt; e0 = eop_cnt;
        ad_switch = ~ad_switch;
        t0 = cyc;
        for (int i = 1; i <= 265; i++) begin
            @(posedge mclk); #1;
            if (i == drop_at)   ad_switch = ~ad_switch;
            if (i == en_off_at) en = 1'b0;
        end
        chk("baddr",    tx_baddr, 64'(blk));
        chk("first_vd", first_vd, 64'(t0 + 3));
        chk("last_vd",  last_vd,  64'(t0 + 258));
        chk("vd_len",   vd_cnt - vd0, 64'd256);
        chk("rd_len",   rd_cnt - rd0, 64'd252);
        chk("eop_len",  eop_cnt - e0, 64'd4);
        chk("eop_rise", eop_rise, 64'(t0 + 259));
        chk("hdr",  mem[blk*256 + 0], 64'hEB90);
        chk("seq",  mem[blk*256 + 1], 64'(s));
        chk("stat", mem[blk*256 + 2], 64'(stat));
        bad = 0;
        sum = 16'h0;
        for (int k = 0; k < 252; k++) begin
            if (mem[blk*256 + 3 + k] !== exp_sample(s, k)) bad++;
            sum = sum + exp_sample(s, k);
        end
        chk("payload", bad, 64'd0);
        chk("csum", mem[blk*256 + 255], 64'(sum));
        chk("idle", busy, 64'd0);
    endtask

    int e0, vd0;

    initial begin
        reset_n   = 1'b0;
        en        = 1'b0;
        ad_switch = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        chk("reset_outs", outs(), 64'd0);
        @(negedge mclk);
        reset_n = 1'b1;
        repeat (4) @(posedge mclk);
        #1;
        chk("post_reset_outs", outs(), 64'd0);
        en = 1'b1;
        repeat (2) @(posedge mclk);

        // 0+1+...+251 = 31626 = 0x7B8A
        run_packet(1, 16'd0, 16'h0001, 0, 0);
`ifndef AD_PACKER_RAMP_EN
        chk("csum_const", mem[1*256 + 255], 64'd31626);
`endif
        for (int p = 1; p < 8; p++)
            run_packet((p % 7) + 1, 16'(p), 16'h0001, 0, 0);

        // second toggle lands on event+100 of this packet
        run_packet(2, 16'd8, 16'h0001, 100, 0);
        chk("ovf_one", ovf_cnt, 64'd1);
        run_packet(3, 16'd9, 16'h0101, 0, 0);

        run_packet(4, 16'd10, 16'h0101, 0, 50);
        @(posedge mclk); #1;
        vd0 = vd_cnt; e0 = eop_cnt;
        ad_switch = ~ad_switch;
        repeat (270) @(posedge mclk);
        #1;
        chk("noen_vd",   vd_cnt - vd0, 64'd0);
        chk("noen_eop",  eop_cnt - e0, 64'd0);
        chk("noen_ovf",  ovf_cnt, 64'd1);
        chk("noen_blk",  tx_baddr, 64'd4);
        en = 1'b1;
        repeat (2) @(posedge mclk);
        #1;
        chk("en_rise_ovf", ovf_cnt, 64'd0);
        run_packet(5, 16'd0, 16'h0001, 0, 0);

        @(posedge mclk); #1;
        e0 = eop_cnt;
        ad_switch = ~ad_switch;
        repeat (102) @(posedge mclk);
        #1;
        chk("mid_busy", busy, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_outs", outs(), 64'd0);
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        reset_n = 1'b1;
        repeat (300) @(posedge mclk);
        #1;
        chk("mid_reset_eop", eop_cnt - e0, 64'd0);
        run_packet(1, 16'd0, 16'h0001, 0, 0);

        chk("blk0_clean", low_hits, 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
